// File: rtl/mfa_pkg.sv
// Shared definitions for the MFA matrix datapath.
// Contents: walk-sequencer FSM state enum and stream FIFO sizing constants.
package mfa_pkg;

    localparam int unsigned STREAM_FIFO_DEPTH = 4;
    // Wide enough to hold 0..STREAM_FIFO_DEPTH inclusive.
    localparam int unsigned STREAM_CNT_W      = $clog2(STREAM_FIFO_DEPTH + 1);
    localparam int unsigned STREAM_IDX_W      = $clog2(STREAM_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mat_stream_fifo.sv
// Small synchronous shift-style FIFO for the read streamer.
// Entry 0 is always the head, so head_data/head_valid come straight from registers.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (caller guarantees space)
//   pop              remove head entry (ignored when empty)
//   head_data        current head entry
//   head_valid       FIFO holds at least one entry
//   count            number of stored entries (0..STREAM_FIFO_DEPTH)
module mat_stream_fifo
    import mfa_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    head_valid,
    output logic [STREAM_CNT_W-1:0] count
);

    logic [WIDTH-1:0]        mem [STREAM_FIFO_DEPTH];
    logic                    do_pop;
    logic                    do_push;
    logic [STREAM_IDX_W-1:0] widx;
    logic [STREAM_CNT_W-1:0] count_n;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != STREAM_CNT_W'(STREAM_FIFO_DEPTH)) || do_pop);
    // A simultaneous pop shifts everything down, so the free slot moves down by one.
    assign widx    = do_pop ? STREAM_IDX_W'(count - STREAM_CNT_W'(1)) : STREAM_IDX_W'(count);
    assign head_data = mem[0];

    // Occupancy update; push and pop together leave it unchanged.
    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + STREAM_CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_n = count - STREAM_CNT_W'(1);
        end
    end

    // Storage, count and head-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STREAM_FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(STREAM_FIFO_DEPTH) - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                mem[widx] <= push_data;
            end
            count      <= count_n;
            head_valid <= (count_n != '0);
        end
    end

endmodule

// File: rtl/mat_rd_streamer.sv
// Matrix RAM read sequencer: walks a row-major sub-matrix, drives the RAM read
// address, hides the 2-cycle registered-read latency and emits a valid/ready
// stream with end-of-row / end-of-matrix tags.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   start                    launch a walk (sampled only in IDLE)
//   base_addr, stride        address of element (0,0) and row pitch
//   n_rows, n_cols           walk dimensions
//   rd_addr / ram_q          RAM read address out, RAM read data in
//   out_data, out_valid      streamed element
//   out_ready                consumer accept
//   out_last_col, out_last   element ends its row / ends the matrix
//   busy                     high outside IDLE
//   done                     one-cycle pulse once the walk is fully drained
module mat_rd_streamer
    import mfa_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 6,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned DIM_LEN  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [ADDR_LEN+1:0] base_addr,
    input  logic [ADDR_LEN+1:0] stride,
    input  logic [DIM_LEN-1:0]  n_rows,
    input  logic [DIM_LEN-1:0]  n_cols,
    output logic [ADDR_LEN+1:0] rd_addr,
    input  logic [DATA_LEN-1:0] ram_q,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last_col,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int unsigned AW = ADDR_LEN + 2;
    localparam int unsigned FW = DATA_LEN + 2;
    localparam int unsigned CW = STREAM_CNT_W + 1;

    state_t                  state_q, state_n;
    logic [AW-1:0]           row_base_q, row_base_n, stride_q, rd_addr_n;
    logic [DIM_LEN-1:0]      col_q, col_n, row_q, row_n, cols_m1_q, rows_m1_q;
    logic [AW-1:0]           cur_base, cur_stride;
    logic [DIM_LEN-1:0]      cur_col, cur_row, cur_cols_m1, cur_rows_m1;
    logic                    is_last_col, is_last, dims_zero;
    logic                    issue, load, busy_n, done_n;
    logic                    iss_q, iss_lc_q, iss_last_q;
    logic                    vld1_q, vld1_lc_q, vld1_last_q;
    logic                    pop, credit_ok;
    logic [STREAM_CNT_W-1:0] fifo_count;
    logic [FW-1:0]           head;
    logic [CW-1:0]           in_use;

    assign pop       = out_valid & out_ready;
    // Reads in the RAM pipe already own a FIFO slot; a same-cycle pop is not credited.
    assign in_use    = CW'(fifo_count) + CW'(iss_q) + CW'(vld1_q);
    assign credit_ok = in_use < CW'(STREAM_FIFO_DEPTH);
    assign dims_zero = (n_rows == '0) || (n_cols == '0);

    // Walk position: live inputs for the first issue out of IDLE, latched copies after.
    always_comb begin
        cur_base    = row_base_q;
        cur_stride  = stride_q;
        cur_col     = col_q;
        cur_row     = row_q;
        cur_cols_m1 = cols_m1_q;
        cur_rows_m1 = rows_m1_q;
        if (state_q == IDLE) begin
            cur_base    = base_addr;
            cur_stride  = stride;
            cur_col     = '0;
            cur_row     = '0;
            cur_cols_m1 = n_cols - DIM_LEN'(1);
            cur_rows_m1 = n_rows - DIM_LEN'(1);
        end
    end

    assign is_last_col = (cur_col == cur_cols_m1);
    assign is_last     = is_last_col && (cur_row == cur_rows_m1);

    // Next-state, issue decision and next values of registered outputs.
    always_comb begin
        state_n    = state_q;
        issue      = 1'b0;
        load       = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        col_n      = col_q;
        row_n      = row_q;
        row_base_n = row_base_q;
        rd_addr_n  = rd_addr;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_zero) begin
                        done_n = 1'b1;
                    end else begin
                        // Pipe and FIFO are empty in IDLE, so credit is always available.
                        load    = 1'b1;
                        issue   = 1'b1;
                        busy_n  = 1'b1;
                        state_n = is_last ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (is_last) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the edge that empties the FIFO with nothing left in the RAM pipe.
                if (!iss_q && !vld1_q &&
                    ((fifo_count == '0) || ((fifo_count == STREAM_CNT_W'(1)) && pop))) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (issue) begin
            rd_addr_n = cur_base + AW'(cur_col);
            if (is_last_col) begin
                col_n      = '0;
                row_n      = cur_row + DIM_LEN'(1);
                row_base_n = cur_base + cur_stride;
            end else begin
                col_n      = cur_col + DIM_LEN'(1);
                row_n      = cur_row;
                row_base_n = cur_base;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Counters, latched walk parameters, outputs and the tag pipe matching RAM latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            row_base_q  <= '0;
            stride_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cols_m1_q   <= '0;
            rows_m1_q   <= '0;
            iss_q       <= 1'b0;
            iss_lc_q    <= 1'b0;
            iss_last_q  <= 1'b0;
            vld1_q      <= 1'b0;
            vld1_lc_q   <= 1'b0;
            vld1_last_q <= 1'b0;
        end else begin
            rd_addr    <= rd_addr_n;
            busy       <= busy_n;
            done       <= done_n;
            row_base_q <= row_base_n;
            col_q      <= col_n;
            row_q      <= row_n;
            if (load) begin
                stride_q  <= stride;
                cols_m1_q <= cur_cols_m1;
                rows_m1_q <= cur_rows_m1;
            end
            iss_q       <= issue;
            iss_lc_q    <= issue & is_last_col;
            iss_last_q  <= issue & is_last;
            vld1_q      <= iss_q;
            vld1_lc_q   <= iss_lc_q;
            vld1_last_q <= iss_last_q;
        end
    end

    mat_stream_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (vld1_q),
        .push_data ({vld1_last_q, vld1_lc_q, ram_q}),
        .pop       (pop),
        .head_data (head),
        .head_valid(out_valid),
        .count     (fifo_count)
    );

    assign {out_last, out_last_col, out_data} = head;

endmodule

// File: tb/tb_mat_rd_streamer.sv
// Self-checking bench for mat_rd_streamer: RAM preloaded with word = address,
// table of directed walks plus hand-written reset, zero-size and address sequences.
module tb_mat_rd_streamer;

    localparam int unsigned ADDR_LEN = 6;
    localparam int unsigned DATA_LEN = 8;
    localparam int unsigned DIM_LEN  = 4;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] stride;
    logic [3:0] n_rows;
    logic [3:0] n_cols;
    logic [7:0] rd_addr;
    logic [7:0] ram_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last_col;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];

    int n_checks;
    int n_pass;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  stride;
        logic [3:0]  rows;
        logic [3:0]  cols;
        int          n;
        logic [47:0] exp_data;   // element i in bits [8i+7:8i]
        int          stall;      // cycles of out_ready low from the first valid
        int          done_cyc;   // loop cycle in which done is expected
        int          probe_cyc;  // 0 = no rd_addr probe
        logic [7:0]  probe_addr;
        bit          mid_start;
    } walk_t;

    walk_t vecs [5];

    mat_rd_streamer #(
        .ADDR_LEN(ADDR_LEN),
        .DATA_LEN(DATA_LEN),
        .DIM_LEN (DIM_LEN)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .base_addr   (base_addr),
        .stride      (stride),
        .n_rows      (n_rows),
        .n_cols      (n_cols),
        .rd_addr     (rd_addr),
        .ram_q       (ram_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last_col(out_last_col),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered-read RAM model.
    always @(posedge CLK) ram_q <= mem[rd_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_walk(input walk_t w, input int vi);
        int got;
        int dones;
        int post;
        int stall_left;
        bit seen_valid;
        bit done_seen;
        got = 0; dones = 0; post = 0; stall_left = 0;
        seen_valid = 1'b0; done_seen = 1'b0;
        base_addr = w.base; stride = w.stride; n_rows = w.rows; n_cols = w.cols;
        out_ready = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        // Scramble inputs: the walk must use the values latched at start.
        start = 1'b0; base_addr = ~w.base; stride = 8'h55; n_rows = 4'hf; n_cols = 4'hf;
        for (int cyc = 1; cyc <= 60 && post < 3; cyc++) begin
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                stall_left = w.stall;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            start = w.mid_start && (cyc == 3);
            @(negedge CLK);
            if (w.probe_cyc == cyc)
                check($sformatf("v%0d rd_addr probe", vi), 32'(rd_addr), 32'(w.probe_addr));
            if (out_valid && got < w.n) begin
                if (out_ready) begin
                    check($sformatf("v%0d data[%0d]", vi, got), 32'(out_data), 32'(w.exp_data[got*8 +: 8]));
                    check($sformatf("v%0d last_col[%0d]", vi, got), 32'(out_last_col),
                          32'((got % int'(w.cols)) == int'(w.cols) - 1));
                    check($sformatf("v%0d last[%0d]", vi, got), 32'(out_last), 32'(got == w.n - 1));
                end else begin
                    check($sformatf("v%0d stalled data[%0d]", vi, got), 32'(out_data), 32'(w.exp_data[got*8 +: 8]));
                end
            end
            if (out_valid && out_ready) got++;
            if (done) begin
                dones++;
                if (!done_seen) begin
                    done_seen = 1'b1;
                    check($sformatf("v%0d done cycle", vi), 32'(cyc), 32'(w.done_cyc));
                    check($sformatf("v%0d busy at done", vi), 32'(busy), 32'd0);
                end
            end
            if (done_seen) post++;
            @(posedge CLK); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check($sformatf("v%0d element count", vi), 32'(got), 32'(w.n));
        check($sformatf("v%0d done pulses", vi), 32'(dones), 32'd1);
    endtask

    initial begin
        logic [47:0] seq_addr;
        n_checks = 0; n_pass = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        vecs[0] = '{8'h00, 8'h08, 4'd2, 4'd3, 6, {8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}, 0, 9, 0, 8'h00, 1'b0};
        vecs[1] = '{8'h00, 8'h08, 4'd2, 4'd3, 6, {8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}, 6, 15, 9, 8'h08, 1'b0};
        vecs[2] = '{8'hFE, 8'h08, 4'd1, 4'd3, 3, {24'h0, 8'h00, 8'hFF, 8'hFE}, 0, 6, 0, 8'h00, 1'b0};
        vecs[3] = '{8'h10, 8'h10, 4'd2, 4'd2, 4, {16'h0, 8'h21, 8'h20, 8'h11, 8'h10}, 0, 7, 0, 8'h00, 1'b1};
        vecs[4] = '{8'h05, 8'h00, 4'd1, 4'd1, 1, {40'h0, 8'h05}, 0, 4, 0, 8'h00, 1'b0};

        RST = 1'b1; start = 1'b0; base_addr = '0; stride = '0;
        n_rows = '0; n_cols = '0; out_ready = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Address sequence of a 2x3 walk, one issue per edge.
        seq_addr = {8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        base_addr = 8'h00; stride = 8'h08; n_rows = 4'd2; n_cols = 4'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("seq busy after start", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge CLK); #1;
            end
            check($sformatf("seq rd_addr[%0d]", i), 32'(rd_addr), 32'(seq_addr[i*8 +: 8]));
        end
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge CLK); #1;
        end
        check("seq drained", 32'(busy), 32'd0);
        @(posedge CLK); #1;

        for (int i = 0; i < 4; i++) run_walk(vecs[i], i);

        // Zero-size walks: done next edge, no data, address untouched (last was 0x21).
        base_addr = 8'h77; stride = 8'h01; n_rows = 4'd0; n_cols = 4'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("zero rows done", 32'(done), 32'd1);
        check("zero rows busy", 32'(busy), 32'd0);
        check("zero rows valid", 32'(out_valid), 32'd0);
        check("zero rows rd_addr", 32'(rd_addr), 32'h21);
        @(posedge CLK); #1;
        check("zero rows done cleared", 32'(done), 32'd0);
        check("zero rows valid later", 32'(out_valid), 32'd0);
        n_rows = 4'd2; n_cols = 4'd0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("zero cols done", 32'(done), 32'd1);
        check("zero cols rd_addr", 32'(rd_addr), 32'h21);
        @(posedge CLK); #1;

        // Reset two cycles into a 4x4 walk at 0x40.
        base_addr = 8'h40; stride = 8'h04; n_rows = 4'd4; n_cols = 4'd4; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre-reset valid", 32'(out_valid), 32'd1);
        RST = 1'b1;
        #1;
        check("mid reset rd_addr", 32'(rd_addr), 32'd0);
        check("mid reset out_data", 32'(out_data), 32'd0);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset last_col", 32'(out_last_col), 32'd0);
        check("mid reset last", 32'(out_last), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        run_walk(vecs[4], 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
